data_memory: RTL and testbench
==============================

# data_memory

Byte-addressable data memory that sits on the far side of the register file's memory port. It accepts load (`lb`) and store (`sw`) requests, stores the register file's `data_out_dm`, and returns load results on `write_data_dm` after a fixed multi-cycle latency. A post-reset init sweep gives the array known contents, and a ready/valid handshake stalls the core while an access is in flight.

## Interface
- `DEPTH`, 32: number of 32-bit words.
- `ADDR_W`, 7: byte-address width; must satisfy 2^ADDR_W >= DEPTH*4.
- `LATENCY`, 2: cycles from acceptance to completion; must be >= 1.
- `clk` in 1: the only clock; all state changes on its rising edge.
- `reset` in 1: asynchronous, active-high.
- `lb` in 1: load request.
- `sw` in 1: store request.
- `size` in 2: access size. 00 = byte, 01 = half, 10 = word, 11 = reserved.
- `load_unsigned` in 1: zero-extend byte/half loads when 1; sign-extend when 0.
- `addr` in ADDR_W: byte address, driven from the register file's `read_data_addr_dm` path.
- `store_data` in 32: store source, driven from the register file's `data_out_dm`.
- `ready` out 1: a request can be accepted this cycle.
- `write_data_dm` out 32: load result; holds its value until the next load completes.
- `load_valid` out 1: one-cycle pulse; `write_data_dm` is valid in this cycle.
- `store_done` out 1: one-cycle pulse; the store has committed.
- `misaligned` out 1: one-cycle pulse; the request was rejected.

## Operation
- **States:**
  - INIT is entered on reset. A counter runs 0..DEPTH-1 and writes mem[i] = i, one word per cycle. `ready` = 0. After the cycle that writes DEPTH-1, the state goes to IDLE.
  - IDLE: `ready` = 1.
  - WAIT: `ready` = 0. The request fields are held in registers and a down-counter is loaded with LATENCY-1.
- **Acceptance:** a request is accepted in IDLE when `lb` or `sw` is high at the rising edge.
  - If `lb` and `sw` are both high, the load wins and `sw` is ignored.
- **Alignment check at acceptance:** the request is misaligned if any of these holds:
  - `size` = 11;
  - `size` = 01 and addr[0] = 1;
  - `size` = 10 and addr[1:0] != 0.
  - A misaligned request does not access memory. `misaligned` pulses in the next cycle and the state stays IDLE.
- **Word index:** addr[ADDR_W-1:2] mod DEPTH (addresses wrap).
- **Store lanes:**
  - Byte: `store_data[7:0]` is written to lane addr[1:0].
  - Half: `store_data[15:0]` is written to lane addr[1].
  - Word: all 32 bits are written.
  - Other lanes are unchanged.
- **Load extraction:** the same lane selection as stores, then sign- or zero-extended per `load_unsigned`. Word loads are not extended.
- **Completion:** memory is read or written at the completion edge. A load accepted after a store to the same word therefore sees the new data.

## Timing
- **Reset values** (asserted asynchronously, immediately): `ready` = 0, `write_data_dm` = 0, `load_valid` = 0, `store_done` = 0, `misaligned` = 0, state = INIT, counters = 0.
- **Reset mid-operation:** the pending request is dropped with no pulse, and the INIT sweep restarts after `reset` deasserts.
- **Init duration:** the first `ready` = 1 occurs DEPTH cycles after the first rising edge with `reset` low.
- **Latency:** for a request accepted at edge N, the state is WAIT from N to N+LATENCY. At edge N+LATENCY the access completes and the state returns to IDLE.
  - In the following cycle `load_valid` or `store_done` is 1 and `ready` is 1.
  - This gives back-to-back throughput of one access per LATENCY+1 cycles.
- **Ignored requests:** `lb` and `sw` are ignored whenever `ready` = 0. The requester must hold them until acceptance.
- **Pulse exclusivity:** at most one of `load_valid`, `store_done`, `misaligned` is high in any cycle.

## Test plan
- **Init sweep:** release `reset` and count cycles.
  - `ready` must stay 0 for exactly 32 cycles.
  - A word load at 0x14 must then return 0x00000005 with `load_valid` in the cycle after completion, 3 cycles after acceptance.
- **Word store, narrow loads:** store word 0xDEADBEEF at 0x08, then load from it.
  - Signed byte at 0x0B -> 0xFFFFFFDE.
  - Unsigned byte at 0x0B -> 0x000000DE.
  - Signed half at 0x08 -> 0xFFFFBEEF.
- **Byte store into an init word:** store byte 0x7F at 0x11, then load word 0x10 -> 0x00007F04.
- **Misaligned requests:** word load at 0x02, half store at 0x05, and `size` = 11.
  - Each must give a `misaligned` pulse in the next cycle, with no `load_valid` or `store_done`.
  - A following word load at 0x04 must return 0x00000001.
- **Simultaneous `lb` + `sw`** at word 0x0C with `store_data` = 0xAAAAAAAA: must give `load_valid` with 0x00000003, no `store_done`, and memory unchanged.
- **Async reset during WAIT:** assert `reset` mid-access.
  - All outputs must go to 0 immediately, with no completion pulse.
  - Memory must re-init, so word 0x08 reads 0x00000002 after the sweep.

Source files
------------

// File: rtl/data_memory.sv
// Byte-addressable data memory with post-reset init sweep, fixed access latency
// and a ready/valid style handshake toward the core.
module data_memory #(
  parameter int unsigned DEPTH   = 32,
  parameter int unsigned ADDR_W  = 7,
  parameter int unsigned LATENCY = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              lb,
  input  logic              sw,
  input  logic [1:0]        size,
  input  logic              load_unsigned,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       store_data,
  output logic              ready,
  output logic [31:0]       write_data_dm,
  output logic              load_valid,
  output logic              store_done,
  output logic              misaligned
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned LAT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {S_INIT, S_IDLE, S_WAIT} state_t;

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  init_cnt_q, init_cnt_d;
  logic [LAT_W-1:0]  lat_cnt_q, lat_cnt_d;
  logic              op_load_q, op_load_d;
  logic [1:0]        size_q, size_d;
  logic              uns_q, uns_d;
  logic [1:0]        lane_q, lane_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [31:0]       sdata_q, sdata_d;

  logic              ready_d, load_valid_d, store_done_d, misaligned_d;
  logic [31:0]       rdata_d;

  logic [31:0]       mem [DEPTH];
  logic              mem_we;
  logic [IDX_W-1:0]  mem_idx;
  logic [3:0]        mem_be;
  logic [31:0]       mem_wdata;

  logic              req_misaligned;
  logic [31:0]       word_rd;
  logic [7:0]        byte_v;
  logic [15:0]       half_v;
  logic [31:0]       load_val;
  logic [3:0]        st_be;
  logic [31:0]       st_wdata;

  // Alignment rule evaluated on the live request
  always_comb begin
    req_misaligned = 1'b0;
    case (size)
      2'b01:   req_misaligned = addr[0];
      2'b10:   req_misaligned = (addr[1:0] != 2'b00);
      2'b11:   req_misaligned = 1'b1;
      default: req_misaligned = 1'b0;
    endcase
  end

  // Lane extraction for loads and lane placement for stores, from held request
  always_comb begin
    word_rd  = mem[idx_q];
    byte_v   = word_rd[{lane_q, 3'b000} +: 8];
    half_v   = word_rd[{lane_q[1], 4'b0000} +: 16];
    load_val = word_rd;
    st_be    = 4'hF;
    st_wdata = sdata_q;
    case (size_q)
      2'b00: begin
        load_val = uns_q ? {24'd0, byte_v} : {{24{byte_v[7]}}, byte_v};
        st_be    = 4'b0001 << lane_q;
        st_wdata = {24'd0, sdata_q[7:0]} << {lane_q, 3'b000};
      end
      2'b01: begin
        load_val = uns_q ? {16'd0, half_v} : {{16{half_v[15]}}, half_v};
        st_be    = lane_q[1] ? 4'b1100 : 4'b0011;
        st_wdata = lane_q[1] ? {sdata_q[15:0], 16'd0} : {16'd0, sdata_q[15:0]};
      end
      default: begin
        load_val = word_rd;
        st_be    = 4'hF;
        st_wdata = sdata_q;
      end
    endcase
  end

  // Next-state and next-output logic
  always_comb begin
    state_d      = state_q;
    init_cnt_d   = init_cnt_q;
    lat_cnt_d    = lat_cnt_q;
    op_load_d    = op_load_q;
    size_d       = size_q;
    uns_d        = uns_q;
    lane_d       = lane_q;
    idx_d        = idx_q;
    sdata_d      = sdata_q;
    ready_d      = 1'b0;
    rdata_d      = write_data_dm;
    load_valid_d = 1'b0;
    store_done_d = 1'b0;
    misaligned_d = 1'b0;
    mem_we       = 1'b0;
    mem_idx      = idx_q;
    mem_be       = 4'h0;
    mem_wdata    = 32'd0;
    case (state_q)
      S_INIT: begin
        mem_we    = 1'b1;
        mem_idx   = init_cnt_q;
        mem_be    = 4'hF;
        mem_wdata = 32'(init_cnt_q);
        if (init_cnt_q == IDX_W'(DEPTH - 1)) begin
          state_d    = S_IDLE;
          ready_d    = 1'b1;
          init_cnt_d = '0;
        end else begin
          init_cnt_d = init_cnt_q + IDX_W'(1);
        end
      end
      S_IDLE: begin
        ready_d = 1'b1;
        if (lb || sw) begin
          if (req_misaligned) begin
            misaligned_d = 1'b1;
          end else begin
            state_d   = S_WAIT;
            ready_d   = 1'b0;
            lat_cnt_d = LAT_W'(LATENCY - 1);
            op_load_d = lb;
            size_d    = size;
            uns_d     = load_unsigned;
            lane_d    = addr[1:0];
            idx_d     = IDX_W'(32'(addr[ADDR_W-1:2]) % DEPTH);
            sdata_d   = store_data;
          end
        end
      end
      S_WAIT: begin
        if (lat_cnt_q == '0) begin
          state_d = S_IDLE;
          ready_d = 1'b1;
          if (op_load_q) begin
            load_valid_d = 1'b1;
            rdata_d      = load_val;
          end else begin
            store_done_d = 1'b1;
            mem_we       = 1'b1;
            mem_be       = st_be;
            mem_wdata    = st_wdata;
          end
        end else begin
          lat_cnt_d = lat_cnt_q - LAT_W'(1);
        end
      end
      default: state_d = S_INIT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_INIT;
      init_cnt_q    <= '0;
      lat_cnt_q     <= '0;
      op_load_q     <= 1'b0;
      size_q        <= 2'b00;
      uns_q         <= 1'b0;
      lane_q        <= 2'b00;
      idx_q         <= '0;
      sdata_q       <= 32'd0;
      ready         <= 1'b0;
      write_data_dm <= 32'd0;
      load_valid    <= 1'b0;
      store_done    <= 1'b0;
      misaligned    <= 1'b0;
    end else begin
      state_q       <= state_d;
      init_cnt_q    <= init_cnt_d;
      lat_cnt_q     <= lat_cnt_d;
      op_load_q     <= op_load_d;
      size_q        <= size_d;
      uns_q         <= uns_d;
      lane_q        <= lane_d;
      idx_q         <= idx_d;
      sdata_q       <= sdata_d;
      ready         <= ready_d;
      write_data_dm <= rdata_d;
      load_valid    <= load_valid_d;
      store_done    <= store_done_d;
      misaligned    <= misaligned_d;
    end
  end

  // Storage array has no reset; contents come from the init sweep
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_be[b]) mem[mem_idx][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_memory.sv
// Randomized self-checking bench for data_memory against a byte-array model.
module tb_data_memory;

  logic        clk = 1'b0;
  logic        reset;
  logic        lb, sw, load_unsigned;
  logic [1:0]  size;
  logic [6:0]  addr;
  logic [31:0] store_data;
  logic        ready, load_valid, store_done, misaligned;
  logic [31:0] write_data_dm;

  int total = 0;
  int bad   = 0;

  logic [7:0] mb [128];

  data_memory #(.DEPTH(32), .ADDR_W(7), .LATENCY(2)) dut (
    .clk(clk), .reset(reset), .lb(lb), .sw(sw), .size(size),
    .load_unsigned(load_unsigned), .addr(addr), .store_data(store_data),
    .ready(ready), .write_data_dm(write_data_dm), .load_valid(load_valid),
    .store_done(store_done), .misaligned(misaligned)
  );

  always #5 clk = ~clk;

  function automatic void m_init();
    for (int j = 0; j < 128; j++) mb[j] = (j % 4 == 0) ? 8'(j / 4) : 8'd0;
  endfunction

  function automatic bit m_misaligned(input logic [1:0] sz, input int a);
    return (sz == 2'd3) || (sz == 2'd1 && (a % 2) != 0) || (sz == 2'd2 && (a % 4) != 0);
  endfunction

  function automatic logic [31:0] m_load(input logic [1:0] sz, input logic u, input int a);
    logic [31:0] v;
    if (sz == 2'd0) begin
      v = {24'd0, mb[a]};
      if (!u && mb[a][7]) v = v | 32'hFFFFFF00;
    end else if (sz == 2'd1) begin
      v = {16'd0, mb[a+1], mb[a]};
      if (!u && mb[a+1][7]) v = v | 32'hFFFF0000;
    end else begin
      v = {mb[a+3], mb[a+2], mb[a+1], mb[a]};
    end
    return v;
  endfunction

  function automatic void m_store(input logic [1:0] sz, input int a, input logic [31:0] d);
    mb[a] = d[7:0];
    if (sz != 2'd0) mb[a+1] = d[15:8];
    if (sz == 2'd2) begin
      mb[a+2] = d[23:16];
      mb[a+3] = d[31:24];
    end
  endfunction

  // Drive one request, then report the first pulse: cycle after acceptance, {lv,sd,mis}, data
  task automatic do_req(input logic l, input logic s, input logic [1:0] sz, input logic u,
                        input logic [6:0] a, input logic [31:0] d,
                        output int cyc, output logic [2:0] pv, output logic [31:0] rd,
                        output logic rdy);
    @(negedge clk);
    rdy = ready;
    lb = l; sw = s; size = sz; load_unsigned = u; addr = a; store_data = d;
    @(posedge clk);
    @(negedge clk);
    lb = 1'b0; sw = 1'b0;
    cyc = 0; pv = 3'b000; rd = 32'd0;
    for (int i = 1; i <= 10; i++) begin
      if (load_valid || store_done || misaligned) begin
        cyc = i;
        pv  = {load_valid, store_done, misaligned};
        rd  = write_data_dm;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (!ready && n < 100) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    int n;
    reset = 1'b1;
    lb = 1'b0; sw = 1'b0; size = 2'd0; load_unsigned = 1'b0; addr = '0; store_data = '0;
    #3;
    total++;
    if ({ready, load_valid, store_done, misaligned, write_data_dm} !== 36'd0) begin
      bad++;
      $display("FAIL reset_outputs got=%h want=0", {ready, load_valid, store_done, misaligned, write_data_dm});
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    m_init();
    wait_ready(n);
    total++;
    if (n !== 32) begin
      bad++;
      $display("FAIL init_sweep_cycles got=%0d want=32", n);
    end
  endtask

  task automatic test_init_load();
    int c; logic [2:0] pv; logic [31:0] rd; logic r;
    do_req(1'b1, 1'b0, 2'd2, 1'b0, 7'h14, 32'd0, c, pv, rd, r);
    total++;
    if (r !== 1'b1) begin bad++; $display("FAIL init_ready got=%b want=1", r); end
    total++;
    if (c !== 3 || pv !== 3'b100) begin
      bad++; $display("FAIL init_load_timing cyc=%0d pulses=%b want cyc=3 pulses=100", c, pv);
    end
    total++;
    if (rd !== m_load(2'd2, 1'b0, 'h14)) begin
      bad++; $display("FAIL init_load_data got=%h want=%h", rd, m_load(2'd2, 1'b0, 'h14));
    end
  endtask

  task automatic test_store_narrow();
    int c; logic [2:0] pv; logic [31:0] rd; logic r;
    do_req(1'b0, 1'b1, 2'd2, 1'b0, 7'h08, 32'hDEADBEEF, c, pv, rd, r);
    m_store(2'd2, 'h08, 32'hDEADBEEF);
    total++;
    if (c !== 3 || pv !== 3'b010) begin
      bad++; $display("FAIL word_store_pulse cyc=%0d pulses=%b want cyc=3 pulses=010", c, pv);
    end
    do_req(1'b1, 1'b0, 2'd0, 1'b0, 7'h0B, 32'd0, c, pv, rd, r);
    total++;
    if (pv !== 3'b100 || rd !== 32'hFFFFFFDE) begin
      bad++; $display("FAIL sbyte_load got=%h pulses=%b want=ffffffde", rd, pv);
    end
    do_req(1'b1, 1'b0, 2'd0, 1'b1, 7'h0B, 32'd0, c, pv, rd, r);
    total++;
    if (pv !== 3'b100 || rd !== 32'h000000DE) begin
      bad++; $display("FAIL ubyte_load got=%h pulses=%b want=000000de", rd, pv);
    end
    do_req(1'b1, 1'b0, 2'd1, 1'b0, 7'h08, 32'd0, c, pv, rd, r);
    total++;
    if (pv !== 3'b100 || rd !== 32'hFFFFBEEF) begin
      bad++; $display("FAIL shalf_load got=%h pulses=%b want=ffffbeef", rd, pv);
    end
  endtask

  task automatic test_byte_store();
    int c; logic [2:0] pv; logic [31:0] rd; logic r;
    do_req(1'b0, 1'b1, 2'd0, 1'b0, 7'h11, 32'h0000007F, c, pv, rd, r);
    m_store(2'd0, 'h11, 32'h7F);
    do_req(1'b1, 1'b0, 2'd2, 1'b0, 7'h10, 32'd0, c, pv, rd, r);
    total++;
    if (pv !== 3'b100 || rd !== 32'h00007F04) begin
      bad++; $display("FAIL byte_store_merge got=%h pulses=%b want=00007f04", rd, pv);
    end
  endtask

  task automatic test_misaligned();
    int c; logic [2:0] pv; logic [31:0] rd; logic r;
    logic [1:0] szs [3];
    logic [6:0] ads [3];
    logic       lds [3];
    szs[0] = 2'd2; ads[0] = 7'h02; lds[0] = 1'b1;
    szs[1] = 2'd1; ads[1] = 7'h05; lds[1] = 1'b0;
    szs[2] = 2'd3; ads[2] = 7'h00; lds[2] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      do_req(lds[k], !lds[k], szs[k], 1'b0, ads[k], 32'hFFFFFFFF, c, pv, rd, r);
      total++;
      if (c !== 1 || pv !== 3'b001) begin
        bad++; $display("FAIL misaligned_%0d cyc=%0d pulses=%b want cyc=1 pulses=001", k, c, pv);
      end
    end
    do_req(1'b1, 1'b0, 2'd2, 1'b0, 7'h04, 32'd0, c, pv, rd, r);
    total++;
    if (pv !== 3'b100 || rd !== 32'h00000001) begin
      bad++; $display("FAIL after_misaligned_load got=%h pulses=%b want=00000001", rd, pv);
    end
  endtask

  task automatic test_lb_sw();
    int c; logic [2:0] pv; logic [31:0] rd; logic r;
    do_req(1'b1, 1'b1, 2'd2, 1'b0, 7'h0C, 32'hAAAAAAAA, c, pv, rd, r);
    total++;
    if (c !== 3 || pv !== 3'b100 || rd !== 32'h00000003) begin
      bad++; $display("FAIL lb_sw_priority cyc=%0d pulses=%b got=%h want cyc=3 pulses=100 data=00000003", c, pv, rd);
    end
    do_req(1'b1, 1'b0, 2'd2, 1'b0, 7'h0C, 32'd0, c, pv, rd, r);
    total++;
    if (rd !== 32'h00000003) begin
      bad++; $display("FAIL lb_sw_mem_unchanged got=%h want=00000003", rd);
    end
  endtask

  task automatic test_random();
    int c; logic [2:0] pv; logic [31:0] rd; logic r;
    logic l, s, u; logic [1:0] sz; logic [6:0] a; logic [31:0] d;
    logic [31:0] exp_d; logic [2:0] exp_pv; int exp_c;
    for (int k = 0; k < 60; k++) begin
      l  = 1'($urandom_range(0, 1));
      s  = l ? 1'($urandom_range(0, 1)) : 1'b1;
      u  = 1'($urandom_range(0, 1));
      sz = 2'($urandom_range(0, 3));
      a  = 7'($urandom_range(0, 127));
      d  = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'd3) sz = 2'($urandom_range(0, 2));
        if (sz == 2'd2) a = a & 7'h7C;
        if (sz == 2'd1) a = a & 7'h7E;
      end
      exp_d = 32'd0;
      if (m_misaligned(sz, int'(a))) begin
        exp_pv = 3'b001; exp_c = 1;
      end else if (l) begin
        exp_pv = 3'b100; exp_c = 3; exp_d = m_load(sz, u, int'(a));
      end else begin
        exp_pv = 3'b010; exp_c = 3;
        m_store(sz, int'(a), d);
      end
      do_req(l, s, sz, u, a, d, c, pv, rd, r);
      total++;
      if (c !== exp_c || pv !== exp_pv || (exp_pv == 3'b100 && rd !== exp_d)) begin
        bad++;
        $display("FAIL random_%0d lb=%b sw=%b size=%0d addr=%h got cyc=%0d pulses=%b data=%h want cyc=%0d pulses=%b data=%h",
                 k, l, s, sz, a, c, pv, rd, exp_c, exp_pv, exp_d);
      end
    end
  endtask

  task automatic test_reset_wait();
    int c, n; logic [2:0] pv; logic [31:0] rd; logic r;
    logic [3:0] seen;
    do_req(1'b0, 1'b1, 2'd2, 1'b0, 7'h08, 32'h12345678, c, pv, rd, r);
    @(negedge clk);
    lb = 1'b1; size = 2'd2; addr = 7'h08;
    @(posedge clk);
    #2;
    lb = 1'b0;
    reset = 1'b1;
    #1;
    total++;
    if ({ready, load_valid, store_done, misaligned, write_data_dm} !== 36'd0) begin
      bad++;
      $display("FAIL reset_in_wait got=%h want=0", {ready, load_valid, store_done, misaligned, write_data_dm});
    end
    seen = 4'd0;
    repeat (4) begin
      @(negedge clk);
      seen = seen | {ready, load_valid, store_done, misaligned};
    end
    reset = 1'b0;
    m_init();
    for (int i = 0; i < 4; i++) begin
      seen = seen | {1'b0, load_valid, store_done, misaligned};
      @(negedge clk);
    end
    total++;
    if (seen !== 4'd0) begin bad++; $display("FAIL reset_no_pulse got=%b want=0000", seen); end
    wait_ready(n);
    total++;
    if (n !== 28) begin bad++; $display("FAIL reinit_ready_wait got=%0d want=28", n); end
    do_req(1'b1, 1'b0, 2'd2, 1'b0, 7'h08, 32'd0, c, pv, rd, r);
    total++;
    if (pv !== 3'b100 || rd !== m_load(2'd2, 1'b0, 'h08)) begin
      bad++; $display("FAIL reinit_load got=%h pulses=%b want=%h", rd, pv, m_load(2'd2, 1'b0, 'h08));
    end
  endtask

  initial begin
    test_reset();
    test_init_load();
    test_store_narrow();
    test_byte_store();
    test_misaligned();
    test_lb_sw();
    test_random();
    test_reset_wait();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
